seq_count_ctrl: RTL and testbench
=================================

# seq_count_ctrl

Controller for the 3-bit sequence counter datapath: holds a programmable 8-entry next-state table, which defaults to the counter's native sequence 0→4→5→1→7→6→3→2→0. It sequences the counter under a valid/ready command interface: load a state, single-step, run N steps or free-run, halt. It detects lock-up states where the next state equals the current one. It sits between the system controller and the counter output consumers; it replaces the hard-wired JK next-state logic with a table that can be reconfigured at run time.

## Interface
- RUN_W, 8, width of run-length argument
- clk  in  1  clock, all state changes on rising edge
- clear  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready at an edge
- cmd_op  in  2  0=LOAD, 1=STEP, 2=RUN, 3=reserved (accepted, no-op, done pulses)
- cmd_arg  in  RUN_W  LOAD: arg[2:0] is the new state; RUN: step count, 0 = free-run
- halt  in  1  level, sampled each edge while running
- cfg_we  in  1  table write strobe
- cfg_addr  in  3  table index (current state)
- cfg_data  in  3  next state for cfg_addr
- q  out  3  counter state
- busy  out  1  STEP/RUN in progress
- done  out  1  one-cycle pulse at command completion
- lock_err  out  1  sticky; lock-up state hit
- cfg_err  out  1  one-cycle pulse; write dropped

## Operation
- FSM states: IDLE, STEP, RUN. cmd_ready = (state==IDLE), combinational.
- LOAD: applied at the accept edge E0. q←arg[2:0], done=1 for one cycle, no busy.
- STEP: E0 enters STEP. At E1, q←tbl[q], done=1, return IDLE.
- RUN N>0: one advance per edge E1..EN. done=1 and IDLE at EN. Free-run (N=0) continues until halt or lock.
- Internal remaining counter, RUN_W bits, loaded at E0. No wrap: it stops at 1→done.
- halt=1 at an edge in RUN/STEP: no advance, done=1, IDLE. halt in IDLE: ignored.
- Lock: at an advancing edge, if tbl[q]==q: q unchanged, lock_err←1, done=1, IDLE. lock_err is cleared only on the next accepted command.
- halt and lock at the same edge: halt wins, lock_err not set.
- halt and the final RUN step at the same edge: halt wins (no advance), single done.
- cfg write in IDLE: takes effect from the next edge. If a write coincides with a command accept, the command's first advance (E1) sees the new entry.
- cfg_we while busy: dropped, cfg_err=1 for one cycle.
- Default table after clear: tbl[0..7] = 4,7,0,2,5,1,3,6.

## Timing
- Reset values: q=0, busy=0, done=0, lock_err=0, cfg_err=0, state IDLE (cmd_ready=1), table = default.
- clear asserted mid-run aborts immediately (asynchronous). No done pulse; the table reverts to default.
- All outputs registered except cmd_ready.
- busy rises at E0 and falls at the completion edge, coincident with done.
- Back-to-back: the next command can be accepted in the cycle after done. LOAD can be accepted every cycle.
- Latency: STEP 1 cycle; RUN N is N cycles.

## Structure
- Package seq_ctrl_pkg holds:
  - STATE_W=3
  - op encodings OP_LOAD/OP_STEP/OP_RUN
  - FSM state enum
  - DEFAULT_NEXT table constant
- Sub-module seq_next_table: 8×3 register file with asynchronous reset to DEFAULT_NEXT, one write port, one combinational read port.

## Test plan
- Reset, RUN arg=8 from q=0 -> q steps 4,5,1,7,6,3,2,0 on E1..E8; done at E8; busy high for 8 cycles.
- LOAD arg=5, then STEP -> q=5 at the accept edge, then q=1 one edge later; done pulses twice.
- Write tbl[6]=6, LOAD 7, RUN arg=0 -> q=6 at E1; at E2 lock_err=1, done=1, q stays 6. The next LOAD clears lock_err.
- RUN arg=0, halt=1 at the 3rd edge -> q=5 (two advances from 0), done once, cmd_ready=1 the next cycle.
- cfg_we during RUN -> cfg_err pulse, table unchanged, sequence unaffected. Assert clear mid-run -> q=0, busy=0, table back to default.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg
// Shared definitions for the sequence counter controller: state width,
// command op encodings, the controller FSM state type and the default
// next-state table, which reproduces the counter's native sequence
// 0->4->5->1->7->6->3->2->0.
package seq_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] seq_state_t;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_STEP = 2'd1;
    localparam logic [1:0] OP_RUN  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2
    } ctrl_state_e;

    // Element [i] is the state that follows state i. The leftmost literal
    // is element [7], so DEFAULT_NEXT[0] = 4, DEFAULT_NEXT[1] = 7, and so on.
    localparam logic [7:0][STATE_W-1:0] DEFAULT_NEXT = {
        3'd6, 3'd3, 3'd1, 3'd5, 3'd2, 3'd0, 3'd7, 3'd4
    };

endpackage

// File: rtl/seq_next_table.sv
// seq_next_table
// 8 x 3 next-state register file. Asynchronous reset restores the native
// counter sequence; one synchronous write port, one combinational read port.
// Ports:
//   clk_i    clock
//   clear_i  asynchronous active-high reset
//   we_i     write strobe
//   waddr_i  write index (current state)
//   wdata_i  next state stored at waddr_i
//   raddr_i  read index
//   rdata_o  next state for raddr_i
module seq_next_table
    import seq_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       clear_i,
    input  logic       we_i,
    input  seq_state_t waddr_i,
    input  seq_state_t wdata_i,
    input  seq_state_t raddr_i,
    output seq_state_t rdata_o
);

    logic [7:0][STATE_W-1:0] tbl_q;

    always_ff @(posedge clk_i or posedge clear_i) begin
        if (clear_i) begin
            tbl_q <= DEFAULT_NEXT;
        end else if (we_i) begin
            tbl_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = tbl_q[raddr_i];

endmodule

// File: rtl/seq_count_ctrl.sv
// seq_count_ctrl
// Sequences a 3-bit counter through a run-time programmable next-state
// table under a valid/ready command interface (LOAD / STEP / RUN N /
// free-run), with halt, lock-up detection and table configuration.
// Ports:
//   clk, clear               clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only while idle)
//   cmd_op, cmd_arg          command op and argument (state or run length)
//   halt                     stops a STEP/RUN at the next edge
//   cfg_we/cfg_addr/cfg_data table write port, honoured only while idle
//   q                        counter state
//   busy, done               activity level and completion pulse
//   lock_err, cfg_err        sticky lock-up flag, dropped-write pulse
module seq_count_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int RUN_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [RUN_W-1:0] cmd_arg,
    input  logic             halt,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [2:0]       cfg_data,
    output logic [2:0]       q,
    output logic             busy,
    output logic             done,
    output logic             lock_err,
    output logic             cfg_err
);

    ctrl_state_e      state_q, state_d;
    seq_state_t       count_q, count_d;
    logic [RUN_W-1:0] remaining_q, remaining_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             lockErr_q, lockErr_d;
    logic             cfgErr_q, cfgErr_d;
    seq_state_t       nextState;
    logic             tableWe;

    // Writes land only while idle, so a write coinciding with a command
    // accept is visible to that command's first advance.
    assign tableWe = cfg_we && (state_q == ST_IDLE);

    seq_next_table u_table (
        .clk_i   (clk),
        .clear_i (clear),
        .we_i    (tableWe),
        .waddr_i (cfg_addr),
        .wdata_i (cfg_data),
        .raddr_i (count_q),
        .rdata_o (nextState)
    );

    assign cmd_ready = (state_q == ST_IDLE);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            lockErr_q   <= 1'b0;
            cfgErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            lockErr_q   <= lockErr_d;
            cfgErr_q    <= cfgErr_d;
        end
    end

    // Priority while active: halt, then lock-up, then a normal advance.
    // remaining_q == 0 during RUN means free-run; otherwise the run ends
    // on the advance taken while it holds 1, so the counter never wraps.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        lockErr_d   = lockErr_q;
        cfgErr_d    = cfg_we && (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    lockErr_d = 1'b0;
                    case (cmd_op)
                        OP_LOAD: begin
                            count_d = cmd_arg[STATE_W-1:0];
                            done_d  = 1'b1;
                        end
                        OP_STEP: state_d = ST_STEP;
                        OP_RUN: begin
                            state_d     = ST_RUN;
                            remaining_d = cmd_arg;
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            ST_STEP, ST_RUN: begin
                if (halt) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (nextState == count_q) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    lockErr_d = 1'b1;
                end else begin
                    count_d = nextState;
                    if ((state_q == ST_STEP) || (remaining_q == RUN_W'(1))) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (remaining_q != '0) begin
                        remaining_d = remaining_q - RUN_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign q        = count_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign lock_err = lockErr_q;
    assign cfg_err  = cfgErr_q;

endmodule

// File: tb/tb_seq_count_ctrl.sv
// tb_seq_count_ctrl
// Directed bench for seq_count_ctrl: inputs are driven and outputs sampled
// 1 ns after each rising edge; expected values are hand-derived constants.
module tb_seq_count_ctrl;

    localparam int RUN_W = 8;

    logic             clk = 1'b0;
    logic             clear;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [RUN_W-1:0] cmd_arg;
    logic             halt;
    logic             cfg_we;
    logic [2:0]       cfg_addr;
    logic [2:0]       cfg_data;
    logic [2:0]       q;
    logic             busy;
    logic             done;
    logic             lock_err;
    logic             cfg_err;

    int checkCount = 0;
    int errorCount = 0;

    seq_count_ctrl #(.RUN_W(RUN_W)) dut (
        .clk       (clk),
        .clear     (clear),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .halt      (halt),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .lock_err  (lock_err),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advances one clock edge and settles just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one command for a single edge (the accept edge E0). Any table
    // write set up by the caller is presented on the same edge.
    task automatic applyStimulus(input logic [1:0] op, input int arg);
        checkOutput("ready_before_cmd", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = RUN_W'(arg);
        tick();
        cmd_valid = 1'b0;
        cfg_we    = 1'b0;
    endtask

    // Checks the registered status outputs in one call.
    task automatic checkStatus(input string tag, input int expQ, input int expBusy,
                               input int expDone);
        checkOutput({tag, "_q"}, int'(q), expQ);
        checkOutput({tag, "_busy"}, int'(busy), expBusy);
        checkOutput({tag, "_done"}, int'(done), expDone);
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int runSeq[8] = '{4, 5, 1, 7, 6, 3, 2, 0};

        clear     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_arg   = '0;
        halt      = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = 3'd0;
        cfg_data  = 3'd0;

        // Reset state
        #12;
        checkStatus("reset", 0, 0, 0);
        checkOutput("reset_lock_err", int'(lock_err), 0);
        checkOutput("reset_cfg_err", int'(cfg_err), 0);
        checkOutput("reset_ready", int'(cmd_ready), 1);
        clear = 1'b0;
        tick();

        // RUN 8 from 0 walks the whole native sequence
        applyStimulus(2'd2, 8);
        checkStatus("run8_e0", 0, 1, 0);
        checkOutput("run8_e0_ready", int'(cmd_ready), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput($sformatf("run8_e%0d_q", i + 1), int'(q), runSeq[i]);
            checkOutput($sformatf("run8_e%0d_busy", i + 1), int'(busy), (i == 7) ? 0 : 1);
            checkOutput($sformatf("run8_e%0d_done", i + 1), int'(done), (i == 7) ? 1 : 0);
        end

        // LOAD 5 back-to-back after done, then STEP
        applyStimulus(2'd0, 5);
        checkStatus("load5", 5, 0, 1);
        applyStimulus(2'd1, 0);
        checkStatus("step_e0", 5, 1, 0);
        tick();
        checkStatus("step_e1", 1, 0, 1);
        tick();
        checkStatus("step_after", 1, 0, 0);

        // Reserved op: done pulse only
        applyStimulus(2'd3, 6);
        checkStatus("reserved", 1, 0, 1);

        // RUN 1 boundary: single advance 1 -> 7
        applyStimulus(2'd2, 1);
        checkStatus("run1_e0", 1, 1, 0);
        tick();
        checkStatus("run1_e1", 7, 0, 1);

        // Table write tbl[6]=6 together with LOAD 7, then free-run hits lock
        cfg_we   = 1'b1;
        cfg_addr = 3'd6;
        cfg_data = 3'd6;
        applyStimulus(2'd0, 7);
        checkStatus("lockload", 7, 0, 1);
        applyStimulus(2'd2, 0);
        tick();
        checkStatus("lock_e1", 6, 1, 0);
        tick();
        checkStatus("lock_e2", 6, 0, 1);
        checkOutput("lock_e2_lock_err", int'(lock_err), 1);
        tick();
        checkOutput("lock_sticky", int'(lock_err), 1);
        checkOutput("lock_after_done", int'(done), 0);
        // Restore tbl[6]=3 with the next LOAD, which also clears lock_err
        cfg_we   = 1'b1;
        cfg_addr = 3'd6;
        cfg_data = 3'd3;
        applyStimulus(2'd0, 0);
        checkStatus("unlockload", 0, 0, 1);
        checkOutput("unlock_lock_err", int'(lock_err), 0);

        // Free-run with halt at the third edge after accept
        applyStimulus(2'd2, 0);
        tick();
        checkStatus("halt_e1", 4, 1, 0);
        tick();
        checkStatus("halt_e2", 5, 1, 0);
        halt = 1'b1;
        tick();
        checkStatus("halt_e3", 5, 0, 1);
        checkOutput("halt_e3_ready", int'(cmd_ready), 1);
        checkOutput("halt_e3_lock_err", int'(lock_err), 0);

        // Halt held in IDLE is ignored; STEP is accepted, then advances 5 -> 1
        applyStimulus(2'd1, 0);
        checkStatus("idlehalt_e0", 5, 1, 0);
        halt = 1'b0;
        tick();
        checkStatus("idlehalt_e1", 1, 0, 1);

        // cfg write during RUN is dropped and flagged
        applyStimulus(2'd0, 0);
        applyStimulus(2'd2, 4);
        cfg_we   = 1'b1;
        cfg_addr = 3'd4;
        cfg_data = 3'd4;
        tick();
        cfg_we = 1'b0;
        checkStatus("cfgbusy_e1", 4, 1, 0);
        checkOutput("cfgbusy_e1_cfg_err", int'(cfg_err), 1);
        tick();
        checkStatus("cfgbusy_e2", 5, 1, 0);
        checkOutput("cfgbusy_e2_cfg_err", int'(cfg_err), 0);
        tick();
        checkStatus("cfgbusy_e3", 1, 1, 0);
        tick();
        checkStatus("cfgbusy_e4", 7, 0, 1);

        // Write tbl[3]=3 with LOAD 7, run, then clear asynchronously mid-run
        cfg_we   = 1'b1;
        cfg_addr = 3'd3;
        cfg_data = 3'd3;
        applyStimulus(2'd0, 7);
        applyStimulus(2'd2, 0);
        tick();
        checkStatus("clrrun_e1", 6, 1, 0);
        tick();
        checkStatus("clrrun_e2", 3, 1, 0);
        #2;
        clear = 1'b1;
        #1;
        checkStatus("clear_mid", 0, 0, 0);
        checkOutput("clear_mid_ready", int'(cmd_ready), 1);
        #3;
        clear = 1'b0;
        tick();
        checkOutput("clear_after_done", int'(done), 0);

        // Table is back to default: from 3 a STEP gives 2
        applyStimulus(2'd0, 3);
        applyStimulus(2'd1, 0);
        tick();
        checkStatus("default_tbl", 2, 0, 1);
        checkOutput("default_tbl_lock_err", int'(lock_err), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
